// File: rtl/coeff_loader_pkg.sv
// Shared definitions for the coefficient loader and its receiver:
// FSM state encoding and default geometry.
package coeff_loader_pkg;

  localparam int DEFAULT_TAPS = 128;
  localparam int DEFAULT_BW   = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    SEND = 3'd2,
    WAIT = 3'd3,
    ACK  = 3'd4
  } state_t;

endpackage

// File: rtl/coeff_loader.sv
// Coefficient loader: a host-written buffer streamed to a receiver as one
// gapless burst, framed by a realign pulse and a completion handshake.
module coeff_loader
  import coeff_loader_pkg::*;
#(
  parameter int TAPS    = DEFAULT_TAPS,
  parameter int BW      = DEFAULT_BW,
  parameter int TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [$clog2(TAPS)-1:0]     wr_addr,
  input  logic signed [BW-1:0]        wr_data,
  input  logic                        start,
  input  logic                        abort,
  output logic                        cfg_vld,
  output logic signed [BW-1:0]        cfg_data,
  output logic                        cfg_done_in,
  input  logic                        cfg_done_out,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int AW = $clog2(TAPS);
  localparam int IW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t                state, state_d;
  logic [IW-1:0]         idx, idx_d;
  logic [TW-1:0]         tcnt, tcnt_d;
  logic                  err_d;
  logic                  cfg_vld_d, cfg_done_in_d, busy_d, done_d;
  logic signed [BW-1:0]  cfg_data_d;

  logic [BW-1:0]         coeff_mem [TAPS];

  // Buffer is deliberately not reset; it only accepts host writes while idle.
  always_ff @(posedge clk) begin
    if (wr_en && state == IDLE) begin
      coeff_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      tcnt        <= '0;
      err         <= 1'b0;
      cfg_vld     <= 1'b0;
      cfg_data    <= '0;
      cfg_done_in <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      tcnt        <= tcnt_d;
      err         <= err_d;
      cfg_vld     <= cfg_vld_d;
      cfg_data    <= cfg_data_d;
      cfg_done_in <= cfg_done_in_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    idx_d   = idx;
    tcnt_d  = tcnt;
    err_d   = err;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_d = SYNC;
            err_d   = 1'b0;
          end
        end
        SYNC: begin
          state_d = SEND;
          idx_d   = '0;
        end
        SEND: begin
          idx_d = idx + IW'(1);
          if (idx == IW'(TAPS - 1)) begin
            state_d = WAIT;
            tcnt_d  = '0;
          end
        end
        WAIT: begin
          if (cfg_done_out) begin
            state_d = ACK;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            tcnt_d = tcnt + TW'(1);
          end
        end
        ACK:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they appear registered in
  // the same cycle the FSM occupies that state.
  always_comb begin
    cfg_vld_d     = (state_d == SEND);
    cfg_done_in_d = (state_d == SYNC) || (state_d == ACK);
    done_d        = (state_d == ACK);
    busy_d        = (state_d != IDLE);
    cfg_data_d    = cfg_data;
    if (cfg_vld_d) begin
      cfg_data_d = coeff_mem[idx_d[AW-1:0]];
    end
  end

endmodule

// File: tb/tb_coeff_loader.sv
// Self-checking bench for coeff_loader with a behavioural receiver and a
// scoreboard of expected words.
module tb_coeff_loader;

  localparam int TAPS    = 128;
  localparam int BW      = 16;
  localparam int TIMEOUT = 16;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  wr_en = 1'b0;
  logic [$clog2(TAPS)-1:0] wr_addr = '0;
  logic signed [BW-1:0]  wr_data = '0;
  logic                  start = 1'b0;
  logic                  abort = 1'b0;
  logic                  cfg_vld, cfg_done_in, busy, done, err;
  logic signed [BW-1:0]  cfg_data;
  logic                  cfg_done_out;

  logic [BW-1:0] model_buf [TAPS];
  logic [BW-1:0] rx_mem [TAPS];
  logic [BW-1:0] exp_q [$];
  int            rx_idx = 0;
  logic          rx_ack_en = 1'b0;
  logic          rx_force = 1'b0;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int vld_cnt = 0, done_cnt = 0, sync_cnt = 0;
  int first_vld_cyc = -1, last_vld_cyc = -1, sync_cyc = -1, err_rise_cyc = -1;
  int start_cyc = 0;
  logic err_prev = 1'b0;

  coeff_loader #(.TAPS(TAPS), .BW(BW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .abort(abort), .cfg_vld(cfg_vld), .cfg_data(cfg_data),
    .cfg_done_in(cfg_done_in), .cfg_done_out(cfg_done_out),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  assign cfg_done_out = (rx_ack_en && rx_idx == TAPS) || rx_force;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Receiver model: realigns on cfg_done_in, stores each valid word.
  initial forever begin
    @(posedge clk);
    if (cfg_done_in) begin
      rx_idx <= 0;
    end else if (cfg_vld && rx_idx < TAPS) begin
      rx_mem[rx_idx] <= cfg_data;
      rx_idx <= rx_idx + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (cfg_done_in && !done) begin
      sync_cnt++;
      sync_cyc = cyc;
    end
    if (done) done_cnt++;
    if (err && !err_prev) err_rise_cyc = cyc;
    err_prev = err;
    if (cfg_vld) begin
      if (vld_cnt == 0) first_vld_cyc = cyc;
      last_vld_cyc = cyc;
      vld_cnt++;
      if (exp_q.size() == 0) checkOutput("unexpected_vld", 32'(cfg_vld), 0);
      else checkOutput("cfg_data", 32'(cfg_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeCoeff(input int addr, input logic [BW-1:0] data, input bit upd);
    wr_en   = 1'b1;
    wr_addr = addr[$clog2(TAPS)-1:0];
    wr_data = data;
    tick();
    wr_en = 1'b0;
    if (upd) model_buf[addr] = data;
  endtask

  // Pulses start and queues the words the receiver should see.
  task automatic applyStimulus();
    for (int i = 0; i < TAPS; i++) begin
      exp_q.push_back(model_buf[i]);
      rx_mem[i] = 16'hDEAD;
    end
    vld_cnt = 0; done_cnt = 0; sync_cnt = 0;
    first_vld_cyc = -1; last_vld_cyc = -1; sync_cyc = -1; err_rise_cyc = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic waitIdle(input int limit);
    int n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_reached", 32'(busy), 0);
    tick();
  endtask

  task automatic checkRx();
    for (int i = 0; i < TAPS; i++) checkOutput("rx_word", 32'(rx_mem[i]), 32'(model_buf[i]));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit found;

    @(negedge clk);
    checkOutput("rst_cfg_vld", 32'(cfg_vld), 0);
    checkOutput("rst_cfg_data", 32'(cfg_data), 0);
    checkOutput("rst_cfg_done_in", 32'(cfg_done_in), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_err", 32'(err), 0);
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] full load with latency check");
    for (int i = 0; i < TAPS; i++) writeCoeff(i, BW'(i + 1), 1'b1);
    rx_ack_en = 1'b1;
    applyStimulus();
    repeat (5) tick();
    rx_force = 1'b1;
    repeat (20) tick();
    rx_force = 1'b0;
    waitIdle(TAPS + 40);
    checkOutput("sync_cycle", sync_cyc, start_cyc);
    checkOutput("sync_width", sync_cnt, 1);
    checkOutput("first_vld_cycle", first_vld_cyc, start_cyc + 1);
    checkOutput("last_vld_cycle", last_vld_cyc, start_cyc + TAPS);
    checkOutput("vld_count", vld_cnt, TAPS);
    checkOutput("done_pulses", done_cnt, 1);
    checkOutput("err_after_load", 32'(err), 0);
    checkOutput("queue_drained", exp_q.size(), 0);
    checkRx();

    $display("[TB] receiver never completes");
    rx_ack_en = 1'b0;
    applyStimulus();
    waitIdle(TAPS + TIMEOUT + 20);
    checkOutput("timeout_err", 32'(err), 1);
    checkOutput("timeout_cycle", err_rise_cyc, last_vld_cyc + 1 + TIMEOUT);
    checkOutput("timeout_done", done_cnt, 0);
    checkOutput("timeout_busy", 32'(busy), 0);

    $display("[TB] abort mid-burst then reload");
    rx_ack_en = 1'b1;
    applyStimulus();
    checkOutput("err_clear_on_start", 32'(err), 0);
    found = 1'b0;
    for (int i = 0; i < TAPS + 10 && !found; i++) begin
      if (cfg_vld && cfg_data == 16'sd51) found = 1'b1;
      else tick();
    end
    checkOutput("abort_reached", 32'(found), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_vld_drop", 32'(cfg_vld), 0);
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_done", 32'(done), 0);
    checkOutput("abort_err", 32'(err), 0);
    checkOutput("abort_words", vld_cnt, 51);
    exp_q.delete();
    tick();
    applyStimulus();
    waitIdle(TAPS + 40);
    checkOutput("reload_vld_count", vld_cnt, TAPS);
    checkOutput("reload_done", done_cnt, 1);
    checkRx();

    $display("[TB] host write while streaming");
    applyStimulus();
    tick();
    writeCoeff(5, 16'h7FFF, 1'b0);
    waitIdle(TAPS + 40);
    checkOutput("word5_rx", 32'(rx_mem[5]), 6);
    applyStimulus();
    waitIdle(TAPS + 40);
    checkOutput("word5_second_load", 32'(rx_mem[5]), 6);

    $display("[TB] reset while waiting for receiver");
    rx_ack_en = 1'b0;
    applyStimulus();
    for (int i = 0; i < TAPS + 10 && !(vld_cnt == TAPS && !cfg_vld); i++) tick();
    repeat (3) tick();
    checkOutput("busy_in_wait", 32'(busy), 1);
    rst = 1'b1;
    #1;
    checkOutput("rstw_cfg_vld", 32'(cfg_vld), 0);
    checkOutput("rstw_cfg_data", 32'(cfg_data), 0);
    checkOutput("rstw_cfg_done_in", 32'(cfg_done_in), 0);
    checkOutput("rstw_busy", 32'(busy), 0);
    checkOutput("rstw_done", 32'(done), 0);
    checkOutput("rstw_err", 32'(err), 0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    rx_ack_en = 1'b1;
    tick();
    applyStimulus();
    waitIdle(TAPS + 40);
    checkOutput("post_rst_vld_count", vld_cnt, TAPS);
    checkOutput("post_rst_done", done_cnt, 1);
    checkRx();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/coeff_loader.md
COEFF_LOADER -- requirements
Module: coeff_loader

Interface
REQ-001 SHALL have parameter TAPS, default 128, number of coefficients per load.
REQ-002 SHALL have parameter BW, default 16, coefficient width in bits.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum cycles to wait for receiver completion.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 wr_en  input  1  host write strobe into the coefficient buffer.
REQ-007 wr_addr  input  clog2(TAPS)  buffer write index.
REQ-008 wr_data  input  BW  signed coefficient to store.
REQ-009 start  input  1  single-cycle request to stream the buffer to the receiver.
REQ-010 abort  input  1  cancel any load in progress.
REQ-011 cfg_vld  output  1  word-valid strobe to the receiver.
REQ-012 cfg_data  output  BW  coefficient word to the receiver.
REQ-013 cfg_done_in  output  1  acknowledge/realign pulse to the receiver.
REQ-014 cfg_done_out  input  1  receiver completion flag.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 done  output  1  one-cycle pulse on successful load.
REQ-017 err  output  1  sticky timeout flag.

Function
REQ-018 SHALL hold a TAPS x BW coefficient buffer, written on wr_en only in IDLE; writes in other states are ignored.
REQ-019 SHALL implement the FSM states IDLE, SYNC, SEND, WAIT, and ACK.
REQ-020 IDLE: start=1 -> SYNC; err cleared on that cycle; start in any other state is ignored.
REQ-021 SYNC: cfg_done_in=1 for exactly one cycle to reset the receiver index; then SEND with idx=0.
REQ-022 SEND: cfg_vld=1 and cfg_data=buffer[idx] each cycle, idx increments, for exactly TAPS consecutive cycles with no gaps; after the idx=TAPS-1 word -> WAIT.
REQ-023 WAIT: cfg_vld=0, counting cycles; cfg_done_out=1 -> ACK; TIMEOUT cycles elapsed without it -> err=1, then IDLE.
REQ-024 ACK: cfg_done_in=1 for one cycle and done=1 for the same cycle; then IDLE.
REQ-025 cfg_vld, cfg_data, cfg_done_in, done and busy SHALL be registered outputs; cfg_data SHALL hold its last value when cfg_vld=0.
REQ-026 Latency SHALL be: start sampled at edge N -> cfg_done_in high in cycle N+1 -> first cfg_vld in cycle N+2 -> last word in cycle N+TAPS+1.
REQ-027 abort=1 in any non-IDLE state SHALL force IDLE next cycle, drop cfg_vld, and leave done=0 and err unchanged; abort has priority over start and state progress.
REQ-028 cfg_done_out=1 seen during SYNC or SEND SHALL be ignored.
REQ-029 idx SHALL be clog2(TAPS)+1 bits wide to avoid wrap at TAPS-1.

Reset
REQ-030 rst=1 SHALL immediately force state=IDLE, idx=0, timeout counter=0, and all outputs 0 (cfg_data=0).
REQ-031 Buffer contents are undefined after reset and are not cleared.
REQ-032 Reset mid-load SHALL abandon the load; the next load's SYNC pulse realigns the receiver.

Structure
REQ-033 The shared package SHALL hold the FSM state encoding and the default TAPS/BW constants used by the receiver.
REQ-034 Single module; the buffer is an inline register array, with no sub-module.

Verification
REQ-035 Write buffer[i]=i+1 for i=0..127, pulse start, paired with the receiver -> 128 consecutive cfg_vld words 1..128, receiver holds identical coefficients, done pulses once, err=0.
REQ-036 Check latency: start at cycle 10 -> cfg_done_in at cycle 11, cfg_vld at cycles 12..139.
REQ-037 Hold cfg_done_out at 0 -> err=1 exactly 16 cycles after entering WAIT, busy=0, done never asserted.
REQ-038 Abort at SEND idx=50 -> cfg_vld low next cycle, then restart -> SYNC pulse realigns the receiver and all 128 words load correctly.
REQ-039 wr_en during SEND to addr 5 with 0x7FFF -> buffer unchanged, word 5 sent as originally written.
REQ-040 Assert rst during WAIT -> all outputs 0 within the same cycle, FSM in IDLE, start accepted normally afterwards.
